video_mode_ctrl: RTL and testbench

Run-time video mode controller for the HDMI/VGA output path. Holds the active timing configuration (porch, sync and polarity fields) driven into the timing generator. Accepts mode-change requests and applies them only at a frame boundary: it blanks video, holds the timing generator in reset, swaps the configuration and releases. Sits between the host/control logic and the timing generator, in the pixel clock domain.

---
 rtl/video_mode_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_video_mode_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/video_mode_ctrl.sv
// +---------------------------------------------------------------------------+
// | video_mode_ctrl: run-time video timing mode switcher, frame-aligned swaps |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
`default_nettype none

module video_mode_ctrl #(
  parameter logic [1:0]  DEFAULT_MODE   = 2'd3,
  parameter logic [3:0]  RST_CYCLES     = 4'd8,
  parameter logic [21:0] TIMEOUT_CYCLES = 22'd2_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  mode_sel,
  input  logic        mode_req,
  input  logic [10:0] h_cnt,
  input  logic [9:0]  v_cnt,
  output logic [10:0] h_visible,
  output logic [10:0] h_front,
  output logic [10:0] h_sync_w,
  output logic [10:0] h_back,
  output logic        h_pol,
  output logic [9:0]  v_visible,
  output logic [9:0]  v_front,
  output logic [9:0]  v_sync_w,
  output logic [9:0]  v_back,
  output logic        v_pol,
  output logic        tim_rst,
  output logic        video_en,
  output logic        busy,
  output logic        mode_ack,
  output logic [1:0]  mode_cur
);

  typedef struct packed {
    logic [10:0] hvis;
    logic [10:0] hfp;
    logic [10:0] hsync;
    logic [10:0] hbp;
    logic        hpol;
    logic [9:0]  vvis;
    logic [9:0]  vfp;
    logic [9:0]  vsync;
    logic [9:0]  vbp;
    logic        vpol;
  } cfg_t;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_FRAME = 2'd1,
    HOLD       = 2'd2,
    RELEASE    = 2'd3
  } state_t;

  function automatic cfg_t mode_cfg(input logic [1:0] m);
    cfg_t c;
    case (m)
      2'd0:    c = '{11'd640,  11'd16,  11'd96,  11'd48,  1'b0, 10'd480, 10'd10, 10'd2, 10'd33, 1'b0};
      2'd1:    c = '{11'd800,  11'd40,  11'd128, 11'd88,  1'b1, 10'd600, 10'd1,  10'd4, 10'd23, 1'b1};
      2'd2:    c = '{11'd1280, 11'd110, 11'd40,  11'd220, 1'b1, 10'd720, 10'd5,  10'd5, 10'd20, 1'b1};
      default: c = '{11'd1440, 11'd80,  11'd152, 11'd232, 1'b1, 10'd900, 10'd1,  10'd3, 10'd28, 1'b1};
    endcase
    return c;
  endfunction

  state_t      state;
  cfg_t        cfg;
  logic [1:0]  target;
  logic        pend_valid;
  logic [1:0]  pend_mode;
  logic [21:0] tmo_cnt;
  logic [3:0]  hold_cnt;

  logic [10:0] h_last;
  logic [9:0]  v_last;
  logic        frame_end;
  logic        nxt_pend_valid;
  logic [1:0]  nxt_pend_mode;
  logic        chain_switch;

  // Frame end is judged against the configuration currently driving the generator.
  assign h_last    = cfg.hvis + cfg.hfp + cfg.hsync + cfg.hbp - 11'd1;
  assign v_last    = cfg.vvis + cfg.vfp + cfg.vsync + cfg.vbp - 10'd1;
  assign frame_end = (h_cnt == h_last) && (v_cnt == v_last);

  // A request arriving this cycle supersedes the stored one.
  assign nxt_pend_valid = mode_req | pend_valid;
  assign nxt_pend_mode  = mode_req ? mode_sel : pend_mode;
  assign chain_switch   = nxt_pend_valid && (nxt_pend_mode != mode_cur);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cfg        <= mode_cfg(DEFAULT_MODE);
      mode_cur   <= DEFAULT_MODE;
      target     <= DEFAULT_MODE;
      pend_valid <= 1'b0;
      pend_mode  <= 2'd0;
      tmo_cnt    <= 22'd0;
      hold_cnt   <= 4'd0;
      tim_rst    <= 1'b0;
      video_en   <= 1'b1;
      busy       <= 1'b0;
      mode_ack   <= 1'b0;
    end else begin
      mode_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (mode_req) begin
            if (mode_sel == mode_cur) begin
              mode_ack <= 1'b1;
            end else begin
              target   <= mode_sel;
              busy     <= 1'b1;
              video_en <= 1'b0;
              tmo_cnt  <= 22'd0;
              state    <= WAIT_FRAME;
            end
          end
        end
        WAIT_FRAME: begin
          if (mode_req) begin
            pend_valid <= 1'b1;
            pend_mode  <= mode_sel;
          end
          if (frame_end || (tmo_cnt == TIMEOUT_CYCLES - 22'd1)) begin
            cfg      <= mode_cfg(target);
            mode_cur <= target;
            tim_rst  <= 1'b1;
            hold_cnt <= 4'd1;
            state    <= HOLD;
          end else begin
            tmo_cnt <= tmo_cnt + 22'd1;
          end
        end
        HOLD: begin
          if (mode_req) begin
            pend_valid <= 1'b1;
            pend_mode  <= mode_sel;
          end
          if (hold_cnt == RST_CYCLES) begin
            tim_rst  <= 1'b0;
            video_en <= 1'b1;
            mode_ack <= 1'b1;
            busy     <= chain_switch;
            state    <= RELEASE;
          end else begin
            hold_cnt <= hold_cnt + 4'd1;
          end
        end
        RELEASE: begin
          pend_valid <= 1'b0;
          if (chain_switch) begin
            target   <= nxt_pend_mode;
            busy     <= 1'b1;
            video_en <= 1'b0;
            tmo_cnt  <= 22'd0;
            state    <= WAIT_FRAME;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign h_visible = cfg.hvis;
  assign h_front   = cfg.hfp;
  assign h_sync_w  = cfg.hsync;
  assign h_back    = cfg.hbp;
  assign h_pol     = cfg.hpol;
  assign v_visible = cfg.vvis;
  assign v_front   = cfg.vfp;
  assign v_sync_w  = cfg.vsync;
  assign v_back    = cfg.vbp;
  assign v_pol     = cfg.vpol;

endmodule

`default_nettype wire

// File: tb/tb_video_mode_ctrl.sv
// +---------------------------------------------------------------------------+
// | tb_video_mode_ctrl: scoreboard bench for the video mode controller        |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
`default_nettype none

module tb_video_mode_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  mode_sel = 2'd0;
  logic        mode_req = 1'b0;
  logic [10:0] h_cnt = 11'd0;
  logic [9:0]  v_cnt = 10'd0;
  logic [10:0] h_visible, h_front, h_sync_w, h_back;
  logic [9:0]  v_visible, v_front, v_sync_w, v_back;
  logic        h_pol, v_pol, tim_rst, video_en, busy, mode_ack;
  logic [1:0]  mode_cur;

  video_mode_ctrl #(
    .DEFAULT_MODE  (2'd3),
    .RST_CYCLES    (4'd8),
    .TIMEOUT_CYCLES(22'd100)
  ) dut (
    .clk(clk), .rst(rst), .mode_sel(mode_sel), .mode_req(mode_req),
    .h_cnt(h_cnt), .v_cnt(v_cnt),
    .h_visible(h_visible), .h_front(h_front), .h_sync_w(h_sync_w), .h_back(h_back),
    .h_pol(h_pol),
    .v_visible(v_visible), .v_front(v_front), .v_sync_w(v_sync_w), .v_back(v_back),
    .v_pol(v_pol),
    .tim_rst(tim_rst), .video_en(video_en), .busy(busy), .mode_ack(mode_ack),
    .mode_cur(mode_cur)
  );

  always #5 clk = ~clk;

  typedef struct {
    int mode;
    int hvis;
    int vvis;
    int busy;
  } exp_t;

  exp_t q[$];
  int   n_total = 0;
  int   n_pass  = 0;
  int   rises   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic push(input int m, input int hv, input int vv, input int b);
    exp_t e;
    e.mode = m; e.hvis = hv; e.vvis = vv; e.busy = b;
    q.push_back(e);
  endtask

  task automatic req(input logic [1:0] m);
    @(negedge clk);
    mode_sel = m;
    mode_req = 1'b1;
    @(negedge clk);
    mode_req = 1'b0;
  endtask

  task automatic wait_idle(input int lim);
    int n = 0;
    while (busy && n < lim) begin
      @(negedge clk);
      n++;
    end
    check("idle_reached", int'(busy), 0);
    @(negedge clk);
  endtask

  task automatic wait_hold(input int lim);
    int n = 0;
    while (!tim_rst && n < lim) begin
      @(negedge clk);
      n++;
    end
    check("hold_reached", int'(tim_rst), 1);
  endtask

  // Monitor: pops the scoreboard on every ack and measures tim_rst pulse widths.
  initial begin
    int run = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        run = 0;
      end else if (tim_rst) begin
        if (run == 0) rises++;
        run++;
      end else if (run != 0) begin
        check("tim_rst_width", run, 8);
        run = 0;
      end
      if (mode_ack) begin
        if (q.size() == 0) begin
          check("unexpected_ack", 1, 0);
        end else begin
          e = q.pop_front();
          check("ack_mode_cur", int'(mode_cur), e.mode);
          check("ack_h_visible", int'(h_visible), e.hvis);
          check("ack_v_visible", int'(v_visible), e.vvis);
          check("ack_video_en", int'(video_en), 1);
          check("ack_busy", int'(busy), e.busy);
        end
      end
    end
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_h_visible", int'(h_visible), 1440);
    check("rst_v_back", int'(v_back), 28);
    check("rst_h_pol", int'(h_pol), 1);
    check("rst_mode_cur", int'(mode_cur), 3);
    check("rst_tim_rst", int'(tim_rst), 0);
    check("rst_video_en", int'(video_en), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_mode_ack", int'(mode_ack), 0);

    // Same-mode request: ack only
    push(3, 1440, 900, 0);
    req(2'd3);
    check("same_busy", int'(busy), 0);
    check("same_video_en", int'(video_en), 1);
    repeat (3) @(negedge clk);
    check("same_no_tim_rst", rises, 0);

    // Frame-aligned switch to mode 0
    push(0, 640, 480, 0);
    req(2'd0);
    check("sw0_video_en", int'(video_en), 0);
    check("sw0_busy", int'(busy), 1);
    check("sw0_tim_rst_pre", int'(tim_rst), 0);
    repeat (50) @(negedge clk);
    check("sw0_cfg_held", int'(h_visible), 1440);
    h_cnt = 11'd1903;
    v_cnt = 10'd931;
    @(negedge clk);
    h_cnt = 11'd0;
    v_cnt = 10'd0;
    check("sw0_tim_rst", int'(tim_rst), 1);
    check("sw0_h_visible", int'(h_visible), 640);
    check("sw0_h_front", int'(h_front), 16);
    check("sw0_h_sync_w", int'(h_sync_w), 96);
    check("sw0_h_back", int'(h_back), 48);
    check("sw0_v_pol", int'(v_pol), 0);
    check("sw0_mode_cur", int'(mode_cur), 0);
    wait_idle(50);
    check("sw0_idle_video_en", int'(video_en), 1);

    // Timeout-forced switch to mode 1 with frozen counters
    push(1, 800, 600, 0);
    req(2'd1);
    n = 0;
    while (!tim_rst && n < 200) begin
      n++;
      @(negedge clk);
    end
    check("tmo_wait_cycles", n, 100);
    check("tmo_h_visible", int'(h_visible), 800);
    check("tmo_v_visible", int'(v_visible), 600);
    wait_idle(50);

    // Chained requests: 0 then 2 then 1; 2 is overwritten
    push(0, 640, 480, 1);
    push(1, 800, 600, 0);
    req(2'd0);
    req(2'd2);
    req(2'd1);
    wait_idle(400);
    check("chain_mode_cur", int'(mode_cur), 1);
    check("chain_h_visible", int'(h_visible), 800);

    // Reset during HOLD with a pending request discarded
    req(2'd2);
    wait_hold(200);
    req(2'd0);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_tim_rst", int'(tim_rst), 0);
    check("mid_rst_h_visible", int'(h_visible), 1440);
    check("mid_rst_v_back", int'(v_back), 28);
    check("mid_rst_mode_cur", int'(mode_cur), 3);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_video_en", int'(video_en), 1);
    @(negedge clk);
    rst = 1'b0;
    repeat (150) @(negedge clk);
    check("post_rst_busy", int'(busy), 0);
    check("post_rst_mode_cur", int'(mode_cur), 3);
    check("tim_rst_rises", rises, 5);
    check("acks_outstanding", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
